// File: rtl/uart_prog_load_ctrl.sv
// rtl/uart_prog_load_ctrl.sv - UART framed program loader into instruction RAM (optional stats: ULOAD_STATS_EN)
module uart_prog_load_ctrl #(
    parameter int INSTR_WIDTH    = 32,
    parameter int DEPTH          = 256,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int ADDR_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_byte,
    input  logic                   rx_done,
    input  logic                   tx_busy,
    output logic [7:0]             tx_byte,
    output logic                   tx_en,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   core_run,
    output logic                   load_busy,
    output logic                   chk_err,
    output logic                   timeout_err,
    output logic [15:0]            ok_cnt,
    output logic [15:0]            err_cnt
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_RUN   = 8'h02;
    localparam logic [7:0] CMD_HALT  = 8'h03;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_CHK,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [TO_W-1:0]        r_to_cnt;
    logic [7:0]             r_cmd;
    logic [7:0]             r_chk;
    logic [ADDR_W-1:0]      r_ptr;
    logic [7:0]             r_words_left;
    logic [1:0]             r_byte_idx;
    logic [23:0]            r_shift;
    logic                   r_wr_en;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [INSTR_WIDTH-1:0] r_wr_data;
    logic [7:0]             r_resp;
    logic                   r_core_run;
    logic                   r_chk_err;
    logic                   r_timeout_err;

    logic                   w_to_run;
    logic                   w_timeout;
    logic                   w_tx_en;
    logic                   w_ack;
    logic                   w_nak;
    logic                   w_word_done;
    logic                   w_cmd_known;
    logic [ADDR_W-1:0]      w_ptr_next;

    assign w_cmd_known = (rx_byte == CMD_WRITE) || (rx_byte == CMD_RUN) || (rx_byte == CMD_HALT);
    assign w_ptr_next  = (r_ptr == ADDR_W'(DEPTH - 1)) ? '0 : r_ptr + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus the single-cycle strobes that steer the datapath
    always_comb begin
        w_next      = r_state;
        w_tx_en     = 1'b0;
        w_ack       = 1'b0;
        w_nak       = 1'b0;
        w_word_done = 1'b0;
        w_to_run    = (r_state != S_IDLE) && (r_state != S_RESP);
        // A byte arriving in the expiry cycle takes priority and reloads the counter
        w_timeout   = w_to_run && !rx_done && (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
        case (r_state)
            S_IDLE: begin
                if (rx_done && rx_byte == SYNC_BYTE) begin
                    w_next = S_CMD;
                end
            end
            S_CMD: begin
                if (rx_done) begin
                    if (rx_byte == CMD_WRITE) begin
                        w_next = S_ADDR;
                    end else if (w_cmd_known) begin
                        w_next = S_CHK;
                    end else begin
                        w_nak  = 1'b1;
                        w_next = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_done) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_done) begin
                    w_next = (rx_byte == 8'd0) ? S_CHK : S_DATA;
                end
            end
            S_DATA: begin
                if (rx_done && r_byte_idx == 2'd3) begin
                    w_word_done = 1'b1;
                    if (r_words_left == 8'd1) begin
                        w_next = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (rx_done) begin
                    w_ack  = (rx_byte == r_chk);
                    w_nak  = (rx_byte != r_chk);
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (!tx_busy) begin
                    w_tx_en = 1'b1;
                    w_next  = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_next = S_IDLE;
        end
    end

    // Inter-byte watchdog: counts idle clocks only while a frame is being parsed
    always_ff @(posedge clk) begin
        if (rst || !w_to_run || rx_done || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Frame parsing datapath: running XOR, word pointer, byte assembly and RAM write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd        <= '0;
            r_chk        <= '0;
            r_ptr        <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
            r_shift      <= '0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
        end else begin
            r_wr_en <= w_word_done;
            if (rx_done) begin
                case (r_state)
                    S_IDLE: begin
                        r_chk <= '0;
                    end
                    S_CMD: begin
                        r_cmd <= rx_byte;
                        r_chk <= r_chk ^ rx_byte;
                    end
                    S_ADDR: begin
                        r_ptr <= rx_byte[ADDR_W-1:0];
                        r_chk <= r_chk ^ rx_byte;
                    end
                    S_LEN: begin
                        r_words_left <= rx_byte;
                        r_byte_idx   <= 2'd0;
                        r_chk        <= r_chk ^ rx_byte;
                    end
                    S_DATA: begin
                        r_chk      <= r_chk ^ rx_byte;
                        r_shift    <= {r_shift[15:0], rx_byte};
                        r_byte_idx <= r_byte_idx + 2'd1;
                        if (w_word_done) begin
                            r_wr_addr    <= r_ptr;
                            r_wr_data    <= {r_shift, rx_byte};
                            r_ptr        <= w_ptr_next;
                            r_words_left <= r_words_left - 8'd1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Response byte, run gating and sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp        <= '0;
            r_core_run    <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            // The fetch FSM is halted as soon as a WRITE is recognised
            if (r_state == S_CMD && rx_done && rx_byte == CMD_WRITE) begin
                r_core_run <= 1'b0;
            end
            if (w_ack) begin
                r_resp <= RESP_ACK;
                if (r_cmd == CMD_RUN) begin
                    r_core_run <= 1'b1;
                end else if (r_cmd == CMD_HALT) begin
                    r_core_run <= 1'b0;
                end
            end
            if (w_nak) begin
                r_resp    <= RESP_NAK;
                r_chk_err <= 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

`ifdef ULOAD_STATS_EN
    logic [15:0] r_ok_cnt;
    logic [15:0] r_err_cnt;

    // Saturating frame outcome counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ok_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_ack && r_ok_cnt != 16'hFFFF) begin
                r_ok_cnt <= r_ok_cnt + 16'd1;
            end
            if ((w_nak || w_timeout) && r_err_cnt != 16'hFFFF) begin
                r_err_cnt <= r_err_cnt + 16'd1;
            end
        end
    end

    assign ok_cnt  = r_ok_cnt;
    assign err_cnt = r_err_cnt;
`else
    assign ok_cnt  = 16'd0;
    assign err_cnt = 16'd0;
`endif

    assign tx_byte     = r_resp;
    assign tx_en       = w_tx_en;
    assign wr_en       = r_wr_en;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign core_run    = r_core_run;
    assign load_busy   = (r_state != S_IDLE);
    assign chk_err     = r_chk_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/uart_prog_load_ctrl.md
Name: uart_prog_load_ctrl

Overview:
Packet-framed program-load controller that sits between the UART wrapper and the instruction RAM write port. It parses SYNC/CMD/ADDR/LEN/DATA/CHK frames from the host and assembles big-endian 32-bit words into memory writes. It answers each frame with ACK or NAK on UART TX and gates the core's run enable, so the fetch FSM is halted while a program is being written.

Parameters:
INSTR_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
DEPTH, 256, instruction RAM depth; must be ≤256; ADDR_W = $clog2(DEPTH)
TIMEOUT_CYCLES, 100000, idle clocks between bytes before an in-progress frame is aborted

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rx_byte  in  8  received byte from UART wrapper
rx_done  in  1  1-cycle strobe; rx_byte valid
tx_busy  in  1  UART transmitter busy
tx_byte  out  8  response byte
tx_en  out  1  1-cycle transmit strobe
wr_en  out  1  instruction RAM write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  INSTR_WIDTH  write data
core_run  out  1  core run enable (0 = fetch halted)
load_busy  out  1  high from the CMD byte until the response is sent
chk_err  out  1  sticky flag: checksum mismatch or unknown command
timeout_err  out  1  sticky flag: inter-byte timeout fired
ok_cnt  out  16  frames ACKed (optional feature)
err_cnt  out  16  frames NAKed or timed out (optional feature)

Behaviour:
- Reset (synchronous): state IDLE. All outputs are 0, including core_run, both flags and both counters.
- Frame format: 0xA5, CMD, [ADDR, LEN, LEN×4 data bytes MSB-first], CHK.
  - CHK is the XOR of every byte after SYNC.
  - CMD 0x01 = WRITE (carries the bracketed fields). CMD 0x02 = RUN, CMD 0x03 = HALT (no bracketed fields).
- IDLE: consumes rx_done bytes. Any byte other than 0xA5 is discarded. 0xA5 → CMD.
- CMD: 0x01 → ADDR, and core_run is cleared in this same cycle. 0x02/0x03 → CHK. Any other value → RESP with NAK, chk_err set.
- ADDR: captures the low ADDR_W bits as the word pointer → LEN.
- LEN: LEN=0 → CHK. Otherwise → DATA.
- DATA: shifts bytes into a 32-bit register.
  - On the 4th byte, the cycle after rx_done: wr_en=1 for 1 cycle, wr_addr = pointer, wr_data = assembled word.
  - The pointer then increments modulo DEPTH (0xFF+1 → 0x00).
  - After LEN words → CHK.
  - Words are committed as received; a bad checksum does not roll them back.
- CHK: compares the running XOR with the received byte.
  - Match → ACK 0x06, and the command is applied: RUN sets core_run=1, HALT clears it, WRITE leaves core_run=0.
  - Mismatch → NAK 0x15, chk_err set, core_run unchanged from its pre-CHK value.
  - → RESP.
- RESP: waits until tx_busy==0, then drives tx_en=1 for one cycle with tx_byte = response; tx_byte is held until the next response. → IDLE.
  - rx_done bytes arriving in RESP are dropped.
- load_busy = 1 in every state except IDLE.
- Timeout:
  - The counter runs in all states except IDLE and RESP, and reloads on every rx_done.
  - On reaching TIMEOUT_CYCLES → IDLE. No response is sent, timeout_err is set, core_run stays 0 if the aborted frame was a WRITE.
  - If rx_done and expiry occur in the same cycle, the byte wins and the counter reloads.
- Sticky flags clear only on rst.
- Reset mid-frame: the partial word is discarded and no wr_en is issued after rst deasserts.

Optional Feature:
ULOAD_STATS_EN
- Defined: ok_cnt increments on each ACK; err_cnt increments on each NAK and each timeout abort. Both saturate at 0xFFFF.
- Undefined: ok_cnt and err_cnt are tied to 0 and no counter logic is generated.

Test Plan:
- Write: A5 01 10 01 DE AD BE EF 32 → one wr_en with wr_addr=0x10, wr_data=0xDEADBEEF; tx_byte=0x06; core_run=0; chk_err=0.
- Run after write: A5 02 02 → ACK 0x06, core_run=1. Then A5 03 03 → ACK 0x06, core_run=0.
- Bad checksum: write frame as in the first case but CHK=0x33 → mem[0x10] still written; NAK 0x15; chk_err=1; ok_cnt unchanged, err_cnt+1 (ULOAD_STATS_EN).
- Wrap and TX backpressure: A5 01 FF 02 + 8 bytes + correct CHK, with tx_busy held high 50 cycles → writes at 0xFF then 0x00; tx_en fires on the first cycle tx_busy==0.
- Timeout: TIMEOUT_CYCLES=64; A5 01 then silence → after 64 idle clocks timeout_err=1, no tx_en, state IDLE; a following valid RUN frame is ACKed.
- Framing noise and reset: bytes 00 FF 5A before A5 02 02 → ignored, ACK sent. rst pulsed after 2 data bytes of a WRITE → no wr_en; all outputs 0.
